// File: rtl/vga_pkg.sv
// Display geometry and VRAM word format shared by display_timing and vram_scheduler.
// Every block that walks the frame imports these constants.
package vga_pkg;

   localparam int H_ACTIVE       = 640;
   localparam int V_ACTIVE       = 480;
   localparam int V_TOTAL        = 525;
   localparam int PIX_W          = 4;
   localparam int DATA_W         = 16;
   localparam int ADDR_W         = 17;
   localparam int PPW            = DATA_W / PIX_W;
   localparam int WORDS_PER_LINE = H_ACTIVE / PPW;
   localparam int FIFO_DEPTH     = 4;

   // Line that follows y, wrapping at the last line of the frame.
   function automatic logic [9:0] next_line(input logic [9:0] y, input logic [9:0] last_line);
      next_line = (y == last_line) ? 10'd0 : y + 10'd1;
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous prefetch FIFO with first-word-fall-through head and a flush input.
// A pop and a push in the same cycle leave the occupancy unchanged.
module pix_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = DATA_W
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic             w_do_pop;
   logic             w_do_push;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign w_do_pop  = pop && (r_occ != '0);
   assign w_do_push = push && ((r_occ != OCC_FULL) || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !rst && !flush) r_mem[r_wr_ptr] <= din;
   end

   assign head  = r_mem[r_rd_ptr];
   assign occ   = r_occ;
   assign empty = (r_occ == '0);

endmodule

// File: rtl/vram_scheduler.sv
// Shares the single-port VRAM between the line prefetcher and host writes; fetches are
// urgent below two buffered words. Define VRAM_SCHED_UFLOW_CNT_EN to add uflow_count.
module vram_scheduler #(
   parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int V_TOTAL    = vga_pkg::V_TOTAL,
   parameter int PIX_W      = vga_pkg::PIX_W,
   parameter int DATA_W     = vga_pkg::DATA_W,
   parameter int ADDR_W     = vga_pkg::ADDR_W,
   parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [9:0]        sx,
   input  logic [9:0]        sy,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [PIX_W-1:0]  pixel,
   output logic              underflow
`ifdef VRAM_SCHED_UFLOW_CNT_EN
   ,
   output logic [15:0]       uflow_count
`endif
);

   localparam int L_PPW   = DATA_W / PIX_W;
   localparam int L_WPL   = H_ACTIVE / L_PPW;
   localparam int WL_W    = $clog2(L_WPL + 1);
   localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
   localparam int LVL_W   = OCC_W + 1;
   localparam int SEL_W   = $clog2(L_PPW);

   localparam logic [9:0]        SX_END    = 10'(H_ACTIVE);
   localparam logic [9:0]        SY_END    = 10'(V_ACTIVE);
   localparam logic [9:0]        SY_LAST   = 10'(V_TOTAL - 1);
   localparam logic [LVL_W-1:0]  LVL_DEPTH = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  LVL_LOW   = LVL_W'(2);
   localparam logic [ADDR_W-1:0] WPL_A     = ADDR_W'(L_WPL);
   localparam logic [WL_W-1:0]   WPL_W     = WL_W'(L_WPL);

   logic [ADDR_W-1:0] r_fetch_addr;
   logic [WL_W-1:0]   r_words_left;
   logic              r_inflight;

   logic [OCC_W-1:0]  w_occ;
   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   logic [9:0]        w_ny;
   logic              w_arm;
   logic [LVL_W-1:0]  w_level;
   logic              w_can_fetch;
   logic              w_urgent;
   logic              w_do_fetch;
   logic              w_do_write;
   logic              w_active_px;
   logic              w_pop;
   logic              w_push;
   logic              w_flush;
   logic [SEL_W-1:0]  w_sel;

   always_comb begin
      w_ny        = vga_pkg::next_line(sy, SY_LAST);
      w_arm       = enable && (sx == SX_END) && (w_ny < SY_END);
      w_level     = LVL_W'(w_occ) + LVL_W'(r_inflight);
      // No fetch on an arm cycle: its data would land in the FIFO being flushed.
      w_can_fetch = !rst && !w_arm && (r_words_left != '0) && (w_level < LVL_DEPTH);
      w_urgent    = w_can_fetch && (w_level < LVL_LOW);
      w_do_fetch  = w_urgent || (w_can_fetch && !wr_valid);
      w_do_write  = !rst && !w_urgent && wr_valid;
   end

   assign wr_ready  = !w_urgent;
   assign mem_en    = w_do_fetch || w_do_write;
   assign mem_we    = w_do_write;
   assign mem_addr  = w_do_write ? wr_addr : (w_do_fetch ? r_fetch_addr : '0);
   assign mem_wdata = w_do_write ? wr_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_addr <= '0;
         r_words_left <= '0;
         r_inflight   <= 1'b0;
      end else if (w_arm) begin
         r_fetch_addr <= ADDR_W'(w_ny) * WPL_A;
         r_words_left <= WPL_W;
         r_inflight   <= 1'b0;
      end else begin
         r_inflight <= w_do_fetch;
         if (w_do_fetch) begin
            r_fetch_addr <= r_fetch_addr + 1'b1;
            r_words_left <= r_words_left - 1'b1;
         end
      end
   end

   assign w_active_px = enable && (sx < SX_END) && (sy < SY_END);
   assign w_sel       = sx[SEL_W-1:0];
   assign w_pop       = w_active_px && !w_empty && (w_sel == '1);
   assign w_push      = r_inflight && !w_arm;
   assign w_flush     = w_arm;

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_flush),
      .push  (w_push),
      .din   (mem_rdata),
      .pop   (w_pop),
      .head  (w_head),
      .occ   (w_occ),
      .empty (w_empty)
   );

   // Pixel 0 of a word sits in the least significant bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel     <= '0;
         underflow <= 1'b0;
      end else if (enable) begin
         if (w_active_px) begin
            if (w_empty) begin
               pixel     <= '0;
               underflow <= 1'b1;
            end else begin
               pixel <= w_head[int'(w_sel) * PIX_W +: PIX_W];
            end
         end else begin
            pixel <= '0;
         end
      end
   end

`ifdef VRAM_SCHED_UFLOW_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         uflow_count <= '0;
      end else if (w_active_px && w_empty && (uflow_count != 16'hFFFF)) begin
         uflow_count <= uflow_count + 16'd1;
      end
   end
`endif

endmodule
